// File: rtl/serial_pkg.sv
// Shared constants for the serial TX arbiter family: FSM encodings, tag header base, byte/requester limits.
package serial_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    localparam logic [7:0] TAG_BASE = 8'hA0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_TAG  = 2'd1;
    localparam state_t ST_DATA = 2'd2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr+1 (mod N), wrapping.
module rr_picker
    import serial_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [MAX_REQ-1:0] w_req;

    assign w_req = MAX_REQ'(req);

    // Scan from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = int'(N); k >= 1; k--) begin
            if (w_req[IDX_W'((int'(ptr) + k) % int'(N))]) begin
                idx = IDX_W'((int'(ptr) + k) % int'(N));
                any = 1'b1;
            end
        end
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/serial_arbiter.sv
// Packet-locked round-robin arbiter in front of the board UART TX serializer.
// Define SERIAL_ARBITER_TAG_EN to prefix each packet with header byte 8'hA0 | source index.
module serial_arbiter
    import serial_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic           tx_valid,
    output logic [W-1:0]   tx_data,
    input  logic           tx_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);

    state_t             r_state, w_state_nxt;
    logic [N-1:0]       r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;

    logic [N-1:0]       w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    logic [MAX_REQ-1:0]        w_valid_pad;
    logic [MAX_REQ-1:0]        w_last_pad;
    logic [MAX_REQ*BYTE_W-1:0] w_data_pad;
    logic                      w_owner_valid;
    logic [W-1:0]              w_owner_data;

    rr_picker #(.N(N)) u_picker (
        .req    (req_valid),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    // Pad to the maximum requester count so the owner index selects without width games.
    assign w_valid_pad   = MAX_REQ'(req_valid);
    assign w_last_pad    = MAX_REQ'(req_last);
    assign w_data_pad    = (MAX_REQ*BYTE_W)'(req_data);
    assign w_owner_valid = w_valid_pad[r_idx];
    assign w_owner_data  = W'(w_data_pad[{r_idx, 3'b000} +: BYTE_W]);

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        tx_valid    = 1'b0;
        tx_data     = '0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = w_pick_onehot;
                if (w_pick_any) begin
                    w_idx_nxt = w_pick_idx;
`ifdef SERIAL_ARBITER_TAG_EN
                    w_state_nxt = ST_TAG;
`else
                    w_state_nxt = ST_DATA;
`endif
                end
            end
`ifdef SERIAL_ARBITER_TAG_EN
            ST_TAG: begin
                tx_valid = 1'b1;
                tx_data  = W'(TAG_BASE | BYTE_W'(r_idx));
                if (tx_ready) begin
                    w_state_nxt = ST_DATA;
                end
            end
`endif
            ST_DATA: begin
                // Owner bytes pass straight through; only the owner ever sees ready.
                tx_valid  = w_owner_valid;
                tx_data   = w_owner_data;
                req_ready = r_grant & {N{tx_ready}};
                if (w_owner_valid && tx_ready && w_last_pad[r_idx]) begin
                    w_ptr_nxt   = r_idx;
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= IDX_W'(N - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule

// File: doc/serial_arbiter.md
# serial_arbiter

Round-robin arbiter that shares the single board UART transmitter (rs232 TX serializer, 12 MHz / 9600 baud on icestick) between up to eight byte-stream requesters. Grants are packet-locked: once a requester wins, it keeps the transmitter until it hands over a byte flagged `last`. The block sits between internal producers (status, debug, response generators) and the serial TX instance in the `icestick` top level.

## Interface

Parameters:
- `N`, 4, number of requesters (legal 2..8)
- `W`, 8, byte width (fixed at 8; parameter present for package constant reuse)

Ports:
- `clk`  input  1  system clock
- `rst_n`  input  1  reset; one clock, asynchronous assert, active-low
- `req_valid`  input  N  requester i has a byte
- `req_data`  input  N*W  byte of requester i in bits [i*W +: W]
- `req_last`  input  N  byte of requester i ends its packet
- `req_ready`  output  N  byte of requester i accepted this cycle
- `tx_valid`  output  1  byte offered to serializer
- `tx_data`  output  W  byte to serializer
- `tx_ready`  input  1  serializer accepts byte
- `grant`  output  N  one-hot current owner, all-zero when idle
- `busy`  output  1  a packet is in progress (state != IDLE)

## Operation

- States: IDLE, TAG (only with tag feature), DATA.
- IDLE: if any `req_valid`, select winner by round-robin starting at index `ptr+1` (mod N), wrapping; register winner into `grant`, go to TAG (if enabled) else DATA. No request: stay, `grant`=0.
- TAG: `tx_valid`=1, `tx_data`=8'hA0 | index; all `req_ready`=0; on `tx_ready` go to DATA.
- DATA: combinational pass-through for owner g: `tx_valid`=`req_valid[g]`, `tx_data`=owner byte, `req_ready[g]`=`tx_ready`; all other `req_ready`=0. Handshake = `tx_valid & tx_ready`. Handshake with `req_last[g]` set: `ptr`<=g, go to IDLE.
- Owner deasserting `req_valid` mid-packet: grant held indefinitely, `tx_valid`=0; no timeout.
- Non-owner requests are ignored until IDLE; requesters must hold data stable while valid and not ready.
- `ptr` reset value N-1, so requester 0 has first priority after reset.

## Timing

- Reset values: `req_ready`=0, `tx_valid`=0, `tx_data`=0, `grant`=0, `busy`=0, state IDLE.
- Request-to-grant latency: 1 cycle (IDLE cycle with request, `grant` visible next cycle).
- First data byte offered in the same cycle as `grant` (no tag) or one accepted tag later.
- One IDLE bubble cycle between consecutive packets, including the same requester re-winning.
- Single-byte packet: first byte with `req_last`=1 ends packet after its handshake.
- `tx_valid`, once high in TAG, stays high until `tx_ready`; in DATA it follows owner valid.
- Reset asserted mid-packet: immediate return to reset values; partial packet abandoned, no completion.

## Configuration

- `SERIAL_ARBITER_TAG_EN` defined: TAG state compiled in; every packet prefixed with header byte 8'hA0 | source index (index in bits [2:0]).
- Undefined: TAG state absent, IDLE goes directly to DATA, packets forwarded untouched.

## Structure

- Shared package `serial_pkg`: state enum (IDLE, TAG, DATA), `TAG_BASE` = 8'hA0, `BYTE_W` = 8, `MAX_REQ` = 8.
- Sub-module `rr_picker`: combinational, inputs request vector and `ptr`, outputs one-hot winner and index plus `any`; reusable by other arbiters.

## Test plan

- Reset, single requester 0 sends 3 bytes 8'h11,8'h22,8'h33 (last on third), `tx_ready` always 1 -> `grant`=4'b0001 cycle after request, tx sees exact bytes, `busy` drops after third handshake.
- All four requesters hold 1-byte packets continuously -> grant order 0,1,2,3,0 with one IDLE cycle between each.
- `tx_ready` toggled 1-of-3 cycles during 4-byte packet -> `tx_data` stable while stalled, no byte lost or duplicated, `req_ready` only on owner.
- Owner drops `req_valid` for 5 cycles mid-packet while requester 2 asserts -> grant unchanged, `tx_valid`=0 for those cycles, requester 2 granted only after owner's last byte.
- `rst_n` pulsed low mid-packet -> all outputs 0 asynchronously; after release requester 0 wins over 3 when both request.
- With `SERIAL_ARBITER_TAG_EN`, requester 3 sends 8'h5A (last) -> tx sees 8'hA3 then 8'h5A; without macro only 8'h5A.
